// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared types, default sizes and address helpers for the logic-analyzer capture path
package la_pkg;

  localparam int LA_ENTRIES = 384;
  localparam int LA_AW      = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMD,
    POST,
    DONE
  } cap_state_t;

  // Modulo-entries increment; callers cast to their own address width.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input int entries);
    return (addr == 32'(entries - 1)) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - command, trigger and sample-RAM signals of the capture controller
interface capture_ctrl_if #(
  parameter int AW  = 9,
  parameter int NCH = 5
) ();

  logic           capture_start;
  logic           en_sample;
  logic [AW-1:0]  trig_pos;
  logic [NCH-1:0] ch_trig;
  logic           prot_trig;
  logic           armed;
  logic           triggered;
  logic           we;
  logic [AW-1:0]  waddr;
  logic           capture_done;
  logic [AW-1:0]  last_addr;

  modport master (
    output capture_start, en_sample, trig_pos, ch_trig, prot_trig,
    input  armed, triggered, we, waddr, capture_done, last_addr
  );

  modport slave (
    input  capture_start, en_sample, trig_pos, ch_trig, prot_trig,
    output armed, triggered, we, waddr, capture_done, last_addr
  );

endinterface

// File: rtl/cap_addr_cnt.sv
// rtl/cap_addr_cnt.sv - modulo-ENTRIES address counter with clear and increment enable
module cap_addr_cnt
  import la_pkg::*;
#(
  parameter int ENTRIES = LA_ENTRIES,
  parameter int AW      = LA_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= AW'(wrap_inc(32'(addr), ENTRIES));
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - sequences pre-trigger fill, armed wait and post-trigger fill of the sample RAM
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = LA_ENTRIES,
  parameter int AW      = LA_AW,
  parameter int NCH     = 5
) (
  input  logic         clk,
  input  logic         rst,
  capture_ctrl_if.slave bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);
  localparam logic [AW-1:0] ENT_AW   = AW'(ENTRIES);

  cap_state_t    state, state_nxt;
  logic [AW-1:0] tp, tp_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] last_q, last_nxt;
  logic          armed_q, armed_nxt;
  logic          trig_q, trig_nxt;
  logic          done_q, done_nxt;
  logic          addr_clr;
  logic          we;
  logic          trig_cond;
  logic [AW-1:0] cnt_inc;
  logic [AW-1:0] waddr;

  assign we        = bus.en_sample & ((state == PRE) | (state == ARMD) | (state == POST));
  assign trig_cond = (&bus.ch_trig[NCH-1:0]) & bus.prot_trig;
  assign cnt_inc   = cnt + AW'(1);

  cap_addr_cnt #(.ENTRIES(ENTRIES), .AW(AW)) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .inc  (we),
    .addr (waddr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tp      <= '0;
      cnt     <= '0;
      last_q  <= '0;
      armed_q <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tp      <= tp_nxt;
      cnt     <= cnt_nxt;
      last_q  <= last_nxt;
      armed_q <= armed_nxt;
      trig_q  <= trig_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tp_nxt    = tp;
    cnt_nxt   = cnt;
    last_nxt  = last_q;
    armed_nxt = armed_q;
    trig_nxt  = trig_q;
    done_nxt  = done_q;
    addr_clr  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.capture_start) begin
          state_nxt = PRE;
          tp_nxt    = (bus.trig_pos > LAST_IDX) ? LAST_IDX : bus.trig_pos;
          cnt_nxt   = '0;
          addr_clr  = 1'b1;
          trig_nxt  = 1'b0;
          done_nxt  = 1'b0;
          armed_nxt = 1'b0;
        end
      end
      PRE: begin
        if (we) begin
          cnt_nxt  = cnt_inc;
          last_nxt = waddr;
          if (cnt_inc == ENT_AW - tp) begin
            state_nxt = ARMD;
            armed_nxt = 1'b1;
          end
        end
      end
      ARMD: begin
        // Tracking every write keeps last_addr right for a zero post-trigger length.
        if (we) begin
          last_nxt = waddr;
        end
        if (trig_cond) begin
          trig_nxt = 1'b1;
          cnt_nxt  = '0;
          if (tp == '0) begin
            state_nxt = DONE;
            armed_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = POST;
          end
        end
      end
      POST: begin
        if (we) begin
          cnt_nxt  = cnt_inc;
          last_nxt = waddr;
          if (cnt_inc == tp) begin
            state_nxt = DONE;
            armed_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.armed        = armed_q;
  assign bus.triggered    = trig_q;
  assign bus.we           = we;
  assign bus.waddr        = waddr;
  assign bus.capture_done = done_q;
  assign bus.last_addr    = last_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed table and sequence checks for capture_ctrl with an 8-entry RAM
module tb_capture_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  capture_ctrl_if #(.AW(4), .NCH(5)) bus ();

  capture_ctrl #(.ENTRIES(8), .AW(4), .NCH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       start;
    logic       en;
    logic [3:0] tpos;
    logic [4:0] ch;
    logic       prot;
    logic       armed;
    logic       trig;
    logic       we;
    logic [3:0] waddr;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic s, input logic e, input logic [3:0] t, input logic [4:0] c,
                              input logic p, input logic a, input logic tr, input logic w,
                              input logic [3:0] wa, input logic d);
    vec_t v;
    v.start = s; v.en = e; v.tpos = t; v.ch = c; v.prot = p;
    v.armed = a; v.trig = tr; v.we = w; v.waddr = wa; v.done = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e, input logic [3:0] t, input logic [4:0] c, input logic p);
    bus.capture_start = s;
    bus.en_sample     = e;
    bus.trig_pos      = t;
    bus.ch_trig       = c;
    bus.prot_trig     = p;
  endtask

  initial begin
    // start, en, trig_pos, ch_trig, prot | armed, triggered, we, waddr, done
    tbl[0]  = mk(1, 1, 3, 5'h00, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 3, 5'h00, 1, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 3, 5'h1F, 1, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 1, 3, 5'h00, 1, 0, 0, 1, 2, 0);
    tbl[4]  = mk(0, 1, 3, 5'h00, 1, 0, 0, 1, 3, 0);
    tbl[5]  = mk(0, 1, 3, 5'h00, 1, 0, 0, 1, 4, 0);
    tbl[6]  = mk(0, 1, 3, 5'h00, 1, 1, 0, 1, 5, 0);
    tbl[7]  = mk(1, 1, 0, 5'h00, 1, 1, 0, 1, 6, 0);
    tbl[8]  = mk(0, 1, 0, 5'h1E, 1, 1, 0, 1, 7, 0);
    tbl[9]  = mk(0, 1, 0, 5'h1F, 0, 1, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 3, 5'h1F, 1, 1, 0, 1, 1, 0);
    tbl[11] = mk(0, 1, 3, 5'h1F, 1, 1, 1, 1, 2, 0);
    tbl[12] = mk(0, 1, 3, 5'h00, 1, 1, 1, 1, 3, 0);
    tbl[13] = mk(0, 1, 3, 5'h00, 1, 1, 1, 1, 4, 0);
    tbl[14] = mk(0, 1, 3, 5'h00, 1, 0, 1, 0, 5, 1);
    tbl[15] = mk(0, 1, 3, 5'h1F, 1, 0, 1, 0, 5, 1);

    rst = 1'b1;
    drive(0, 0, 0, 5'h00, 1);
    @(negedge clk);
    chk("rst armed", 32'(bus.armed), 0);
    chk("rst triggered", 32'(bus.triggered), 0);
    chk("rst we", 32'(bus.we), 0);
    chk("rst waddr", 32'(bus.waddr), 0);
    chk("rst done", 32'(bus.capture_done), 0);
    chk("rst last_addr", 32'(bus.last_addr), 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Main acquisition: PRE fill, ignored start/trigger, qualification, POST fill, DONE hold.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].start, tbl[i].en, tbl[i].tpos, tbl[i].ch, tbl[i].prot);
      @(negedge clk);
      chk($sformatf("row%0d armed", i), 32'(bus.armed), 32'(tbl[i].armed));
      chk($sformatf("row%0d triggered", i), 32'(bus.triggered), 32'(tbl[i].trig));
      chk($sformatf("row%0d we", i), 32'(bus.we), 32'(tbl[i].we));
      chk($sformatf("row%0d waddr", i), 32'(bus.waddr), 32'(tbl[i].waddr));
      chk($sformatf("row%0d done", i), 32'(bus.capture_done), 32'(tbl[i].done));
      next_cycle();
    end
    chk("main last_addr", 32'(bus.last_addr), 4);

    // trig_pos = 0: 8 PRE writes, 20 armed cycles wrapping, trigger goes straight to DONE.
    drive(1, 1, 0, 5'h00, 1);
    next_cycle();
    bus.capture_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("tp0 pre%0d waddr", i), 32'(bus.waddr), 32'(i));
      chk($sformatf("tp0 pre%0d armed", i), 32'(bus.armed), 0);
      next_cycle();
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("armwait%0d armed", i), 32'(bus.armed), 1);
      chk($sformatf("armwait%0d we", i), 32'(bus.we), 1);
      chk($sformatf("armwait%0d waddr", i), 32'(bus.waddr), 32'(i % 8));
      next_cycle();
    end
    bus.ch_trig = 5'h1F;
    @(negedge clk);
    chk("tp0 trig waddr", 32'(bus.waddr), 4);
    next_cycle();
    bus.ch_trig = 5'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("tp0 done%0d done", i), 32'(bus.capture_done), 1);
      chk($sformatf("tp0 done%0d armed", i), 32'(bus.armed), 0);
      chk($sformatf("tp0 done%0d triggered", i), 32'(bus.triggered), 1);
      chk($sformatf("tp0 done%0d we", i), 32'(bus.we), 0);
      chk($sformatf("tp0 done%0d waddr", i), 32'(bus.waddr), 5);
      chk($sformatf("tp0 done%0d last_addr", i), 32'(bus.last_addr), 4);
      next_cycle();
    end

    // Reset asserted mid-POST clears everything without waiting for a clock edge.
    drive(1, 1, 3, 5'h00, 1);
    next_cycle();
    bus.capture_start = 1'b0;
    repeat (5) next_cycle();
    bus.ch_trig = 5'h1F;
    next_cycle();
    bus.ch_trig = 5'h00;
    next_cycle();
    chk("post armed", 32'(bus.armed), 1);
    chk("post triggered", 32'(bus.triggered), 1);
    chk("post waddr", 32'(bus.waddr), 7);
    #1;
    rst = 1'b1;
    #1;
    chk("async armed", 32'(bus.armed), 0);
    chk("async triggered", 32'(bus.triggered), 0);
    chk("async we", 32'(bus.we), 0);
    chk("async waddr", 32'(bus.waddr), 0);
    chk("async done", 32'(bus.capture_done), 0);
    chk("async last_addr", 32'(bus.last_addr), 0);
    next_cycle();
    next_cycle();
    chk("held rst we", 32'(bus.we), 0);
    chk("held rst waddr", 32'(bus.waddr), 0);
    rst = 1'b0;
    next_cycle();

    // Fresh start with trig_pos above range: clamps to 7, one PRE write, POST wraps to 0.
    drive(1, 1, 15, 5'h00, 1);
    next_cycle();
    bus.capture_start = 1'b0;
    @(negedge clk);
    chk("clamp pre waddr", 32'(bus.waddr), 0);
    chk("clamp pre we", 32'(bus.we), 1);
    chk("clamp pre armed", 32'(bus.armed), 0);
    next_cycle();
    bus.ch_trig = 5'h1F;
    @(negedge clk);
    chk("clamp armd armed", 32'(bus.armed), 1);
    chk("clamp armd waddr", 32'(bus.waddr), 1);
    next_cycle();
    bus.ch_trig = 5'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("clamp post%0d waddr", i), 32'((i + 2) % 8), 32'(bus.waddr) ^ 32'd0 ^ 32'd0 + 32'd0 + 0);
      chk($sformatf("clamp post%0d done", i), 32'(bus.capture_done), 0);
      next_cycle();
    end
    @(negedge clk);
    chk("clamp done", 32'(bus.capture_done), 1);
    chk("clamp armed", 32'(bus.armed), 0);
    chk("clamp we", 32'(bus.we), 0);
    chk("clamp last_addr", 32'(bus.last_addr), 0);
    chk("clamp waddr", 32'(bus.waddr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
